// File: rtl/muldiv_ctrl.sv
// Sequencer between the CPU control unit and the iterative multiplier/divider.
// Holds a unit's run enable for a fixed cycle count, then commits its result to HI/LO.
module muldiv_ctrl #(
   parameter int MULT_CYCLES = 33,
   parameter int DIV_CYCLES  = 33
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   input  logic [31:0] mult_hi,
   input  logic [31:0] mult_lo,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r,
   output logic        mult_ctrl,
   output logic        div_ctrl,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   typedef enum logic [1:0] {IDLE, MULT_RUN, DIV_RUN, WRITE} state_t;

   localparam logic [5:0] MULT_LAST = 6'(MULT_CYCLES - 1);
   localparam logic [5:0] DIV_LAST  = 6'(DIV_CYCLES - 1);

   state_t     state;
   logic [5:0] cnt;
   logic       is_div;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         is_div    <= 1'b0;
         mult_ctrl <= 1'b0;
         div_ctrl  <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         hi        <= '0;
         lo        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // Moves land first; a start in the same cycle later overwrites them in WRITE.
               if (hi_we) hi <= wdata;
               if (lo_we) lo <= wdata;
               if (start) begin
                  op_a     <= rs_data;
                  op_b     <= rt_data;
                  cnt      <= '0;
                  is_div   <= op;
                  div_zero <= 1'b0;
                  if (!op) begin
                     state     <= MULT_RUN;
                     mult_ctrl <= 1'b1;
                     busy      <= 1'b1;
                  end else if (rt_data != '0) begin
                     state    <= DIV_RUN;
                     div_ctrl <= 1'b1;
                     busy     <= 1'b1;
                  end else begin
                     // Divide by zero never runs the unit; flag it and finish immediately.
                     div_zero <= 1'b1;
                     done     <= 1'b1;
                  end
               end
            end
            MULT_RUN: begin
               if (cnt == MULT_LAST) begin
                  mult_ctrl <= 1'b0;
                  state     <= WRITE;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            DIV_RUN: begin
               if (cnt == DIV_LAST) begin
                  div_ctrl <= 1'b0;
                  state    <= WRITE;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            WRITE: begin
               if (is_div) begin
                  hi <= div_r;
                  lo <= div_q;
               end else begin
                  hi <= mult_hi;
                  lo <= mult_lo;
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with behavioural multiplier/divider units that
// only produce a result after exactly 33 consecutive enabled cycles.
module tb_muldiv_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b0, start = 1'b0, op = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
   logic [31:0] rs_data = '0, rt_data = '0, wdata = '0;
   logic [31:0] mult_hi = '0, mult_lo = '0, div_q = '0, div_r = '0;
   logic        mult_ctrl, div_ctrl, busy, done, div_zero;
   logic [31:0] op_a, op_b, hi, lo;
   int          checks = 0, failures = 0;
   int          mcnt = 0, dcnt = 0;
   int          mh, dh, bc, dc, dn, anom;
   logic [31:0] h1;

   always #5 clk = ~clk;

   muldiv_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .mult_hi(mult_hi), .mult_lo(mult_lo),
      .div_q(div_q), .div_r(div_r), .mult_ctrl(mult_ctrl), .div_ctrl(div_ctrl),
      .op_a(op_a), .op_b(op_b), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
   );

   function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] x, y;
      x = $signed(a);
      y = $signed(b);
      return 64'(x * y);
   endfunction

   // Units clear when their enable is low; result appears only on the 33rd enabled edge.
   always @(posedge clk) begin
      if (mult_ctrl) begin
         mcnt <= mcnt + 1;
         if (mcnt == 32) {mult_hi, mult_lo} <= smul(op_a, op_b);
      end else begin
         mcnt <= 0; mult_hi <= '0; mult_lo <= '0;
      end
      if (div_ctrl) begin
         dcnt <= dcnt + 1;
         if (dcnt == 32 && op_b != 0) begin div_q <= op_a / op_b; div_r <= op_a % op_b; end
      end else begin
         dcnt <= 0; div_q <= '0; div_r <= '0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Issues one start and observes 40 cycles; inj adds a start+moves at cycle 5,
   // mv adds an hi_we move in the same cycle as the start.
   task automatic run(input logic o, input logic [31:0] a, input logic [31:0] b,
                      input bit inj, input bit mv,
                      output int mh_o, output int dh_o, output int bc_o, output int dc_o,
                      output int dn_o, output int an_o, output logic [31:0] h1_o);
      @(negedge clk);
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      if (mv) begin hi_we = 1'b1; wdata = 32'h11111111; end
      mh_o = 0; dh_o = 0; bc_o = 0; dc_o = -1; dn_o = 0; an_o = 0; h1_o = '0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
         if (inj && k == 5) begin
            start = 1'b1; op = ~o; rs_data = 32'h55; rt_data = 32'h3;
            hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
         end
         if (k == 1) h1_o = hi;
         mh_o += int'(mult_ctrl);
         dh_o += int'(div_ctrl);
         bc_o += int'(busy);
         if (done) begin dn_o++; if (dc_o < 0) dc_o = k; end
         if (mult_ctrl && div_ctrl) an_o++;
         if (busy && done) an_o++;
         if ((mult_ctrl || div_ctrl) && (op_a !== a || op_b !== b)) an_o++;
      end
   endtask

   initial begin
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_hi", hi, 0);            chk("rst_lo", lo, 0);
      chk("rst_busy", 32'(busy), 0);   chk("rst_done", 32'(done), 0);
      chk("rst_dz", 32'(div_zero), 0); chk("rst_mctrl", 32'(mult_ctrl), 0);
      chk("rst_dctrl", 32'(div_ctrl), 0); chk("rst_opa", op_a, 0);
      reset = 1'b1;

      // MTHI / MTLO in IDLE
      hi_we = 1'b1; wdata = 32'hA5A5A5A5;
      @(negedge clk);
      hi_we = 1'b0; chk("mthi", hi, 32'hA5A5A5A5);
      lo_we = 1'b1; wdata = 32'h0F0F0F0F;
      @(negedge clk);
      lo_we = 1'b0; chk("mtlo", lo, 32'h0F0F0F0F); chk("mthi_keep", hi, 32'hA5A5A5A5);

      // MULT 7 * -3 with a start and moves injected while busy
      run(1'b0, 32'd7, 32'hFFFFFFFD, 1'b1, 1'b0, mh, dh, bc, dc, dn, anom, h1);
      chk("mul_mctrl_cycles", mh, 33); chk("mul_dctrl_cycles", dh, 0);
      chk("mul_busy_cycles", bc, 34);  chk("mul_done_cycle", dc, 35);
      chk("mul_done_count", dn, 1);    chk("mul_anomalies", anom, 0);
      chk("mul_hi", hi, 32'hFFFFFFFF); chk("mul_lo", lo, 32'hFFFFFFEB);

      // DIV 100 / 7
      run(1'b1, 32'd100, 32'd7, 1'b0, 1'b0, mh, dh, bc, dc, dn, anom, h1);
      chk("div_dctrl_cycles", dh, 33); chk("div_mctrl_cycles", mh, 0);
      chk("div_done_cycle", dc, 35);   chk("div_done_count", dn, 1);
      chk("div_anomalies", anom, 0);   chk("div_busy_after", 32'(busy), 0);
      chk("div_hi", hi, 32'd2);        chk("div_lo", lo, 32'd14);
      chk("div_dz", 32'(div_zero), 0);

      // DIV 5 / 0
      run(1'b1, 32'd5, 32'd0, 1'b0, 1'b0, mh, dh, bc, dc, dn, anom, h1);
      chk("dz_flag", 32'(div_zero), 1); chk("dz_done_cycle", dc, 1);
      chk("dz_done_count", dn, 1);      chk("dz_dctrl_cycles", dh, 0);
      chk("dz_busy_cycles", bc, 0);     chk("dz_hi", hi, 32'd2);
      chk("dz_lo", lo, 32'd14);

      // Reset at cycle 10 of a MULT
      @(negedge clk);
      start = 1'b1; op = 1'b0; rs_data = 32'h1234; rt_data = 32'h5678;
      for (int k = 1; k <= 9; k++) begin @(negedge clk); start = 1'b0; end
      chk("pre_rst_mctrl", 32'(mult_ctrl), 1);
      reset = 1'b0;
      @(negedge clk);
      chk("ab_mctrl", 32'(mult_ctrl), 0); chk("ab_hi", hi, 0); chk("ab_lo", lo, 0);
      chk("ab_busy", 32'(busy), 0);       chk("ab_opa", op_a, 0); chk("ab_opb", op_b, 0);
      chk("ab_done", 32'(done), 0);       chk("ab_dz", 32'(div_zero), 0);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      chk("ab_no_write_hi", hi, 0); chk("ab_no_done", 32'(done), 0);

      // MULT 2 * 3 with a simultaneous MTHI
      run(1'b0, 32'd2, 32'd3, 1'b0, 1'b1, mh, dh, bc, dc, dn, anom, h1);
      chk("mv_hi_early", h1, 32'h11111111);
      chk("m23_hi", hi, 0); chk("m23_lo", lo, 32'd6); chk("m23_done_count", dn, 1);

      // div_zero sticky, then cleared by the next accepted start
      run(1'b1, 32'h20, 32'd0, 1'b0, 1'b0, mh, dh, bc, dc, dn, anom, h1);
      chk("dz2_sticky", 32'(div_zero), 1);
      chk("dz2_keep_lo", lo, 32'd6);
      run(1'b1, 32'hFFFFFFFF, 32'h10, 1'b0, 1'b0, mh, dh, bc, dc, dn, anom, h1);
      chk("dz2_cleared", 32'(div_zero), 0);
      chk("div2_hi", hi, 32'hF); chk("div2_lo", lo, 32'h0FFFFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 33: consecutive cycles mult_ctrl is held high per multiply (1 load plus 32 Booth steps).
REQ-002 SHALL have parameter DIV_CYCLES, default 33: consecutive cycles div_ctrl is held high per divide.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-005 SHALL have port start  in  1  request from the CPU control unit; sampled only in IDLE.
REQ-006 SHALL have port op  in  1  0 = MULT, 1 = DIV; sampled with start.
REQ-007 SHALL have ports rs_data, rt_data  in  32  operands; sampled with start.
REQ-008 SHALL have ports hi_we, lo_we  in  1  MTHI/MTLO write strobes.
REQ-009 SHALL have port wdata  in  32  MTHI/MTLO data.
REQ-010 SHALL have ports mult_hi, mult_lo  in  32  multiplier results (high word, low word).
REQ-011 SHALL have ports div_q, div_r  in  32  divider quotient and remainder.
REQ-012 SHALL have ports mult_ctrl, div_ctrl  out  1  registered run enables to the multiplier and divider; low clears the unit.
REQ-013 SHALL have ports op_a, op_b  out  32  registered operands to the units (op_a = rs, op_b = rt).
REQ-014 SHALL have ports hi, lo  out  32  HI and LO architectural registers.
REQ-015 SHALL have ports busy, done, div_zero  out  1  status outputs.

Function
REQ-016 SHALL implement states IDLE, MULT_RUN, DIV_RUN and WRITE, with a 6-bit cycle counter.
REQ-017 In IDLE with start=1 at edge E0, SHALL latch op_a/op_b, clear the counter, clear div_zero, and set mult_ctrl=1 (MULT) or div_ctrl=1 (DIV, rt_data != 0).
REQ-018 In MULT_RUN, SHALL keep mult_ctrl high and op_a/op_b stable for exactly MULT_CYCLES edges (E1..E33), then drop mult_ctrl at E33 and enter WRITE.
REQ-019 DIV_RUN SHALL behave identically using div_ctrl and DIV_CYCLES.
REQ-020 In WRITE (edge E34), SHALL load hi<=mult_hi and lo<=mult_lo for MULT, or hi<=div_r and lo<=div_q for DIV, pulse done=1 for one cycle, and return to IDLE.
REQ-021 SHALL assert busy whenever state != IDLE (cycles after E0 through E34); busy SHALL be low while done is high.
REQ-022 For DIV with rt_data == 0 at start: no run; at E0 SHALL set div_zero=1, pulse done at E0 (visible in the following cycle), leave hi/lo unchanged, and stay in IDLE.
REQ-023 div_zero SHALL be sticky until the next accepted start or reset.
REQ-024 start while busy SHALL be ignored (no latch, no queue).
REQ-025 hi_we/lo_we in IDLE SHALL write wdata to hi/lo at that edge; while busy they SHALL be ignored.
REQ-026 hi_we/lo_we and start in the same IDLE cycle SHALL both take effect; the later WRITE overwrites the moved value.
REQ-027 SHALL leave the counter width and wrap irrelevant, since the counter is cleared at every start and never exceeds 33.
REQ-028 mult_ctrl and div_ctrl SHALL never be high simultaneously.

Reset
REQ-029 With reset=0 at a rising edge, SHALL go to IDLE and clear the counter, mult_ctrl, div_ctrl, op_a, op_b, hi, lo, busy, done and div_zero to 0, regardless of state.
REQ-030 Reset during RUN SHALL abort the operation: no WRITE, hi/lo become 0, and mult_ctrl drops within the same edge so the multiplier clears.
REQ-031 Reset SHALL take priority over start, hi_we and lo_we.

Verification
REQ-032 MULT rs=7, rt=0xFFFFFFFD -> mult_ctrl high exactly 33 cycles; done one cycle after E34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 DIV rs=100, rt=7 -> div_ctrl high 33 cycles; lo=14, hi=2, done single pulse, busy low afterwards.
REQ-034 DIV rs=5, rt=0 -> div_zero=1, done next cycle, hi/lo keep their prior values, div_ctrl never high.
REQ-035 reset=0 at cycle 10 of a MULT -> all outputs 0, mult_ctrl low next cycle; a new MULT 2*3 then gives hi=0, lo=6.
REQ-036 start asserted at cycle 5 of a run -> ignored, single done; hi_we with wdata=0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5; the same write while busy -> hi unchanged.
